// File: rtl/alu_pkg.sv
// Shared opcodes, MDU state encoding and opcode helpers for the ALU/MDU slice.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_ANDN  = 4'b0100;
  localparam logic [3:0] ALU_ORN   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_XOR   = 4'b1001;
  localparam logic [3:0] ALU_NOR   = 4'b1010;
  localparam logic [3:0] ALU_MULT  = 4'b1100;
  localparam logic [3:0] ALU_MULTU = 4'b1101;
  localparam logic [3:0] ALU_DIV   = 4'b1110;
  localparam logic [3:0] ALU_DIVU  = 4'b1111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_t;

  // All four MDU codes share the 11xx prefix.
  function automatic logic is_mdu(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Execute-stage bus between the datapath/controller and the ALU/MDU block.
interface alu_mdu_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [3:0]       alucontrol;
  logic             start;
  logic [WIDTH-1:0] aluresult;
  logic             zero;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output srca, srcb, alucontrol, start,
    input  aluresult, zero, busy, done, hi, lo
  );

  modport slave (
    input  srca, srcb, alucontrol, start,
    output aluresult, zero, busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_seq.sv
// Iterative multiply/divide core: shift-add multiply and restoring divide on
// unsigned magnitudes, one bit per cycle, with sign fix-up on the last edge.
//
//   state  | meaning
//   S_IDLE | waiting for go; hi/lo hold last result
//   S_RUN  | one iteration per cycle; count==0 is the final iteration
module mdu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [1:0]       kind,   // [1]=divide, [0]=unsigned
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_t       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   acc;     // product high half / partial remainder
  logic [WIDTH-1:0] shreg;   // multiplier bits / dividend->quotient bits
  logic [WIDTH-1:0] bop;     // multiplicand / divisor magnitude
  logic [WIDTH-1:0] a_raw;   // original dividend, returned as hi on divide-by-zero
  logic             is_div, neg_q, neg_r, div0;

  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [WIDTH:0]     acc_n;
  logic [WIDTH-1:0]   sh_n;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  // Operand signs and magnitudes presented at launch.
  always_comb begin
    sa    = !kind[0] && a[WIDTH-1];
    sb    = !kind[0] && b[WIDTH-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
  end

  // Next iteration of whichever algorithm is running.
  always_comb begin
    mul_sum   = shreg[0] ? acc + {1'b0, bop} : acc;
    div_shift = {acc[WIDTH-1:0], shreg[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, bop};
    acc_n     = '0;
    sh_n      = '0;
    if (is_div) begin
      if (!div_diff[WIDTH+1]) begin
        acc_n = div_diff[WIDTH:0];
        sh_n  = {shreg[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = div_shift;
        sh_n  = {shreg[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_n = {1'b0, mul_sum[WIDTH:1]};
      sh_n  = {mul_sum[0], shreg[WIDTH-1:1]};
    end
  end

  // Sign fix-up applied to the final iteration's values. MIN/-1 needs no
  // special case: negating the quotient magnitude 2^(WIDTH-1) yields MIN.
  always_comb begin
    prod   = {acc_n[WIDTH-1:0], sh_n};
    fin_hi = '0;
    fin_lo = '0;
    if (neg_q) prod = -prod;
    if (!is_div) begin
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end else if (div0) begin
      fin_hi = a_raw;
      fin_lo = '1;
    end else begin
      fin_lo = neg_q ? -sh_n : sh_n;
      fin_hi = neg_r ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0];
    end
  end

  // MDU state machine with registered busy/done and HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      count  <= '0;
      acc    <= '0;
      shreg  <= '0;
      bop    <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            acc    <= '0;
            shreg  <= mag_a;
            bop    <= mag_b;
            a_raw  <= a;
            is_div <= kind[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            div0   <= (b == '0);
            count  <= CNT_W'(WIDTH - 1);
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc   <= acc_n;
          shreg <= sh_n;
          if (count == '0) begin
            hi    <= fin_hi;
            lo    <= fin_lo;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with combinational result/zero and an attached
// iterative multiply/divide unit gated by the start/busy handshake.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_mdu_if.slave bus
);

  localparam int CW = 4;

  logic [CW-1:0]    op;
  logic [WIDTH-1:0] a, b, result;
  logic             go;

  assign op = bus.alucontrol;
  assign a  = bus.srca;
  assign b  = bus.srcb;

  // Single-cycle ALU result; MDU codes and unused codes read as zero.
  always_comb begin
    result = '0;
    case (op)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_ANDN: result = a & ~b;
      ALU_ORN:  result = a | ~b;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, a < b};
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      default:  result = '0;
    endcase
  end

  assign bus.aluresult = result;
  assign bus.zero      = (result == '0);

  // The done cycle has busy low, so a start there launches with no bubble.
  assign go = bus.start && is_mdu(op) && !bus.busy;

  mdu_seq #(.WIDTH(WIDTH)) u_mdu_seq (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .kind  (op[1:0]),
    .a     (a),
    .b     (b),
    .busy  (bus.busy),
    .done  (bus.done),
    .hi    (bus.hi),
    .lo    (bus.lo)
  );

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu at WIDTH=32 and WIDTH=8.
module tb_alu_mdu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_mdu_if #(.WIDTH(32)) bus32();
  alu_mdu_if #(.WIDTH(8))  bus8();

  alu_mdu #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
  alu_mdu #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch a 32-bit MDU op from the current cycle and return just after edge k+32.
  task automatic do_op32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cyc, output bit early_done);
    busy_cyc   = 0;
    early_done = 1'b0;
    bus32.alucontrol = op;
    bus32.srca  = a;
    bus32.srcb  = b;
    bus32.start = 1'b1;
    step();
    bus32.start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (bus32.busy) busy_cyc++;
      if (bus32.done) early_done = 1'b1;
      if (i < 31) step();
    end
    step();
  endtask

  task automatic test_reset();
    bus32.srca = '0; bus32.srcb = '0; bus32.alucontrol = ALU_AND; bus32.start = 1'b0;
    bus8.srca  = '0; bus8.srcb  = '0; bus8.alucontrol  = ALU_AND; bus8.start  = 1'b0;
    reset = 1'b1;
    step(); step();
    n_total++; if (bus32.hi !== 32'h0) $display("FAIL reset_hi: got %h expected %h", bus32.hi, 32'h0); else n_pass++;
    n_total++; if (bus32.lo !== 32'h0) $display("FAIL reset_lo: got %h expected %h", bus32.lo, 32'h0); else n_pass++;
    n_total++; if ({bus32.busy, bus32.done} !== 2'b00) $display("FAIL reset_busy_done: got %b expected 00", {bus32.busy, bus32.done}); else n_pass++;
    n_total++; if ({bus8.busy, bus8.done, bus8.hi, bus8.lo} !== 18'h0) $display("FAIL reset_w8: got %h expected 0", {bus8.busy, bus8.done, bus8.hi, bus8.lo}); else n_pass++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_comb();
    vec_t v [17] = '{
      '{ALU_SLT,   32'hFFFFFFFF, 32'h1, 32'h1},
      '{ALU_SLTU,  32'hFFFFFFFF, 32'h1, 32'h0},
      '{ALU_NOR,   32'hFFFFFFFF, 32'h1, 32'h0},
      '{ALU_SUB,   32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE},
      '{ALU_AND,   32'hFFFFFFFF, 32'h1, 32'h1},
      '{ALU_OR,    32'hF0F00000, 32'h1, 32'hF0F00001},
      '{ALU_ADD,   32'hFFFFFFFF, 32'h1, 32'h0},
      '{ALU_ANDN,  32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE},
      '{ALU_ORN,   32'h00000000, 32'h1, 32'hFFFFFFFE},
      '{ALU_XOR,   32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE},
      '{ALU_SLT,   32'h1, 32'hFFFFFFFF, 32'h0},
      '{ALU_SLTU,  32'h1, 32'hFFFFFFFF, 32'h1},
      '{ALU_SLT,   32'h5, 32'h5, 32'h0},
      '{ALU_SUB,   32'h5, 32'h5, 32'h0},
      '{4'b0011,   32'h12345678, 32'h1, 32'h0},
      '{4'b1011,   32'h12345678, 32'h1, 32'h0},
      '{ALU_MULT,  32'h12345678, 32'h1, 32'h0}
    };
    bus32.start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus32.alucontrol = v[i].op;
      bus32.srca = v[i].a;
      bus32.srcb = v[i].b;
      #1;
      n_total++;
      if (bus32.aluresult !== v[i].exp || bus32.zero !== (v[i].exp == 32'h0))
        $display("FAIL comb_%0d op=%b: got %h/%b expected %h/%b", i, v[i].op,
                 bus32.aluresult, bus32.zero, v[i].exp, (v[i].exp == 32'h0));
      else n_pass++;
    end
    step();
  endtask

  task automatic test_mult();
    int  bc;
    bit  ed;
    do_op32(ALU_MULT, 32'hFFFFFFFD, 32'h7, bc, ed);
    n_total++; if (bc !== 32 || ed !== 1'b0) $display("FAIL mult_latency: got busy=%0d early=%0d expected 32/0", bc, ed); else n_pass++;
    n_total++; if ({bus32.done, bus32.busy} !== 2'b10) $display("FAIL mult_done: got %b expected 10", {bus32.done, bus32.busy}); else n_pass++;
    n_total++; if ({bus32.hi, bus32.lo} !== 64'hFFFFFFFF_FFFFFFEB) $display("FAIL mult_hilo: got %h expected %h", {bus32.hi, bus32.lo}, 64'hFFFFFFFF_FFFFFFEB); else n_pass++;
    step();
    do_op32(ALU_MULTU, 32'hFFFFFFFF, 32'h2, bc, ed);
    n_total++; if ({bus32.done, bus32.hi, bus32.lo} !== {1'b1, 64'h00000001_FFFFFFFE}) $display("FAIL multu_hilo: got %h expected %h", {bus32.done, bus32.hi, bus32.lo}, {1'b1, 64'h00000001_FFFFFFFE}); else n_pass++;
    step();
  endtask

  task automatic test_div();
    int bc;
    bit ed;
    do_op32(ALU_DIV, 32'hFFFFFFF9, 32'h2, bc, ed);
    n_total++; if ({bus32.done, bus32.hi, bus32.lo} !== {1'b1, 64'hFFFFFFFF_FFFFFFFD}) $display("FAIL div_neg7_2: got %h expected %h", {bus32.done, bus32.hi, bus32.lo}, {1'b1, 64'hFFFFFFFF_FFFFFFFD}); else n_pass++;
    step();
    do_op32(ALU_DIVU, 32'h7, 32'h0, bc, ed);
    n_total++; if ({bus32.done, bus32.hi, bus32.lo} !== {1'b1, 64'h00000007_FFFFFFFF}) $display("FAIL divu_by0: got %h expected %h", {bus32.done, bus32.hi, bus32.lo}, {1'b1, 64'h00000007_FFFFFFFF}); else n_pass++;
    n_total++; if (bc !== 32) $display("FAIL divu_by0_latency: got %0d expected 32", bc); else n_pass++;
    step();
    do_op32(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, bc, ed);
    n_total++; if ({bus32.hi, bus32.lo} !== 64'h00000000_80000000) $display("FAIL div_min_m1: got %h expected %h", {bus32.hi, bus32.lo}, 64'h00000000_80000000); else n_pass++;
    step();
    do_op32(ALU_DIV, 32'h7, 32'hFFFFFFFE, bc, ed);
    n_total++; if ({bus32.hi, bus32.lo} !== 64'h00000001_FFFFFFFD) $display("FAIL div_7_neg2: got %h expected %h", {bus32.hi, bus32.lo}, 64'h00000001_FFFFFFFD); else n_pass++;
    step();
    do_op32(ALU_DIV, 32'hFFFFFFFB, 32'h0, bc, ed);
    n_total++; if ({bus32.hi, bus32.lo} !== 64'hFFFFFFFB_FFFFFFFF) $display("FAIL div_neg_by0: got %h expected %h", {bus32.hi, bus32.lo}, 64'hFFFFFFFB_FFFFFFFF); else n_pass++;
    step();
    do_op32(ALU_DIVU, 32'hFFFFFFFF, 32'h10, bc, ed);
    n_total++; if ({bus32.hi, bus32.lo} !== 64'h0000000F_0FFFFFFF) $display("FAIL divu_big: got %h expected %h", {bus32.hi, bus32.lo}, 64'h0000000F_0FFFFFFF); else n_pass++;
    step();
  endtask

  task automatic test_handshake();
    int bc;
    bit ed;
    bus32.alucontrol = ALU_MULT; bus32.srca = 32'd3; bus32.srcb = 32'd5; bus32.start = 1'b1;
    step();                                   // edge k
    bus32.start = 1'b0;
    for (int i = 0; i < 4; i++) step();       // edge k+4
    bus32.srca = 32'd100; bus32.srcb = 32'd100; bus32.start = 1'b1;
    step();                                   // edge k+5, must be ignored
    bus32.start = 1'b0;
    bus32.alucontrol = ALU_ADD; bus32.srca = 32'd5; bus32.srcb = 32'd6;
    #1;
    n_total++; if ({bus32.aluresult, bus32.zero, bus32.busy} !== {32'd11, 1'b0, 1'b1}) $display("FAIL add_while_busy: got %h/%b/%b expected 0000000b/0/1", bus32.aluresult, bus32.zero, bus32.busy); else n_pass++;
    for (int i = 0; i < 26; i++) step();      // edge k+31
    n_total++; if ({bus32.busy, bus32.done} !== 2'b10) $display("FAIL restart_k31: got %b expected 10", {bus32.busy, bus32.done}); else n_pass++;
    step();                                   // edge k+32
    n_total++; if ({bus32.done, bus32.hi, bus32.lo} !== {1'b1, 64'd15}) $display("FAIL restart_ignored: got %h expected %h", {bus32.done, bus32.hi, bus32.lo}, {1'b1, 64'd15}); else n_pass++;
    do_op32(ALU_MULTU, 32'd6, 32'd7, bc, ed); // launched in the done cycle
    n_total++; if (bc !== 32 || ed !== 1'b0) $display("FAIL b2b_latency: got busy=%0d early=%0d expected 32/0", bc, ed); else n_pass++;
    n_total++; if ({bus32.done, bus32.hi, bus32.lo} !== {1'b1, 64'd42}) $display("FAIL b2b_result: got %h expected %h", {bus32.done, bus32.hi, bus32.lo}, {1'b1, 64'd42}); else n_pass++;
    step();
    n_total++; if ({bus32.done, bus32.lo} !== {1'b0, 32'd42}) $display("FAIL done_pulse_hold: got %h expected %h", {bus32.done, bus32.lo}, {1'b0, 32'd42}); else n_pass++;
    bus32.alucontrol = ALU_ADD; bus32.start = 1'b1;
    step();
    bus32.start = 1'b0;
    n_total++; if (bus32.busy !== 1'b0) $display("FAIL nonmdu_start: got busy=%b expected 0", bus32.busy); else n_pass++;
    step();
  endtask

  task automatic test_reset_midop();
    bit seen_done;
    bus32.alucontrol = ALU_MULTU; bus32.srca = 32'hFFFF; bus32.srcb = 32'hFFFF; bus32.start = 1'b1;
    step();
    bus32.start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_total++; if ({bus32.busy, bus32.done, bus32.hi, bus32.lo} !== 66'h0) $display("FAIL reset_midop: got %h expected 0", {bus32.busy, bus32.done, bus32.hi, bus32.lo}); else n_pass++;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus32.done || bus32.busy) seen_done = 1'b1;
    end
    n_total++; if (seen_done !== 1'b0) $display("FAIL reset_no_done: got activity=%b expected 0", seen_done); else n_pass++;
  endtask

  task automatic test_width8();
    int bc;
    bit ed;
    bc = 0; ed = 1'b0;
    bus8.alucontrol = ALU_MULT; bus8.srca = 8'h80; bus8.srcb = 8'h80; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus8.busy) bc++;
      if (bus8.done) ed = 1'b1;
      if (i < 7) step();
    end
    step();
    n_total++; if (bc !== 8 || ed !== 1'b0) $display("FAIL w8_latency: got busy=%0d early=%0d expected 8/0", bc, ed); else n_pass++;
    n_total++; if ({bus8.done, bus8.hi, bus8.lo} !== {1'b1, 16'h4000}) $display("FAIL w8_mult: got %h expected %h", {bus8.done, bus8.hi, bus8.lo}, {1'b1, 16'h4000}); else n_pass++;
    bus8.alucontrol = ALU_DIVU; bus8.srca = 8'd200; bus8.srcb = 8'd7; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    n_total++; if ({bus8.done, bus8.hi, bus8.lo} !== {1'b1, 8'd4, 8'd28}) $display("FAIL w8_divu: got %h expected %h", {bus8.done, bus8.hi, bus8.lo}, {1'b1, 8'd4, 8'd28}); else n_pass++;
    bus8.alucontrol = ALU_ADD; bus8.srca = 8'hFF; bus8.srcb = 8'h01;
    #1;
    n_total++; if ({bus8.aluresult, bus8.zero} !== {8'h00, 1'b1}) $display("FAIL w8_add_wrap: got %h/%b expected 00/1", bus8.aluresult, bus8.zero); else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_comb();
    test_mult();
    test_div();
    test_handshake();
    test_reset_midop();
    test_width8();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Parametrised-width successor to the single-cycle MIPS ALU. It keeps the combinational ALU path and extends it with unsigned compare, XOR and NOR. It also adds an iterative multiply/divide unit (MDU) with architectural HI/LO registers and a start/busy/done handshake. The block sits in the execute stage: the datapath reads aluresult/zero the same cycle, and the controller stalls on busy for MULT/DIV.

Parameters:
WIDTH, 32, operand/result width in bits; legal range 4..64.
CW, 4, alucontrol width; fixed at 4, not overridable.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
srca  in  WIDTH  operand A
srcb  in  WIDTH  operand B
alucontrol  in  4  operation select
start  in  1  launch MDU op; honoured only when alucontrol[3:2]==2'b11 and busy==0
aluresult  out  WIDTH  combinational ALU result
zero  out  1  aluresult==0, combinational
busy  out  1  MDU iteration in progress
done  out  1  one-cycle pulse; HI/LO updated on the same edge
hi  out  WIDTH  HI register (product high half / remainder)
lo  out  WIDTH  LO register (product low half / quotient)

Behaviour:
- Combinational ops; aluresult valid in the same cycle, independent of MDU state:
  - 0000 AND, 0001 OR, 0010 ADD (wraps, no overflow flag), 0100 A&~B, 0101 A|~B, 0110 SUB.
  - 0111 SLT signed, 1000 SLTU unsigned; both give 1 or 0, zero-extended.
  - 1001 XOR, 1010 NOR.
  - 0011, 1011 and 11xx: aluresult=0, so zero=1.
- MDU codes: 1100 MULT signed, 1101 MULTU, 1110 DIV signed, 1111 DIVU.
- Reset (synchronous): hi=0, lo=0, busy=0, done=0, FSM=IDLE. Reset mid-operation aborts the op with no done pulse and clears hi/lo.
- FSM states:
  - IDLE: if start && MDU code, then at that edge latch operand magnitudes, signs and op kind; count=WIDTH-1; go to RUN; busy=1.
  - RUN: one iteration per cycle (shift-add multiply, restoring divide) on unsigned magnitudes. At the edge where count==0, apply sign fix-up, write hi/lo, set done=1 and busy=0, and return to IDLE. Otherwise decrement count.
- Latency: start sampled at edge k; busy high after edges k..k+WIDTH-1; hi/lo and done take effect after edge k+WIDTH. MDU busy time is WIDTH cycles.
- done stays high for exactly one cycle. start in the done cycle is accepted, giving back-to-back ops with no bubble.
- start while busy is ignored; operands are not re-latched.
- start with a non-MDU code is ignored by the MDU.
- Signed multiply: 2*WIDTH product; {hi,lo}=product.
- Signed divide truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero (signed or unsigned): lo=all ones, hi=srca. This takes the same latency and is not an error.
- Signed overflow MIN/-1: lo=MIN, hi=0.
- hi/lo hold their values between ops and are never written except on done or reset.

Decomposition:
- Package alu_pkg holds:
  - The 4-bit opcode localparams (ALU_AND .. ALU_DIVU).
  - The FSM state encoding (S_IDLE, S_RUN).
  - An is_mdu(op) function.
- Sub-module mdu_seq holds the iterative multiply/divide core, its counter and the sign fix-up.
- Top alu_mdu holds the combinational ALU case, the zero flag and the handshake gating.

Test Plan:
1. WIDTH=32, srca=0xFFFFFFFF, srcb=1. Expect SLT=1, SLTU=0, NOR=0x00000000 with zero=1, SUB=0xFFFFFFFE.
2. MULT of -3 (0xFFFFFFFD) by 7, start at edge k. Expect busy for 32 cycles, done after edge k+32, hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU of 0xFFFFFFFF by 2 expects hi=1, lo=0xFFFFFFFE.
3. DIV -7/2: expect lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0: expect lo=0xFFFFFFFF, hi=7. DIV 0x80000000/-1: expect lo=0x80000000, hi=0.
4. Handshake:
   - Pulse start again mid-op with new operands: result reflects only the first op.
   - Assert start in the done cycle: second op completes exactly 32 cycles later.
   - Combinational ADD 5+6=11 stays correct while busy.
5. Reset mid-op: assert reset 10 cycles into a MULT. Expect busy=0, hi=lo=0 the next cycle, and no done pulse ever.
6. WIDTH=8 build: MULT 0x80*0x80 expects hi=0x40, lo=0x00 after 8 cycles. ADD 0xFF+0x01 expects aluresult=0x00, zero=1.
